// File: rtl/if_id_imm_stage.sv
// IF/ID pipeline register: captures instruction/PC, pre-decodes the immediate format
// and exposes raw immediate slices. Define IF_ID_STALL_CNT_EN to add a saturating stall counter.
module if_id_imm_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  valid_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc4_o,
  output logic                  valid_o,
  output logic [11:0]           imm12_i_o,
  output logic [11:0]           imm12_s_o,
  output logic [11:0]           imm12_b_o,
  output logic [19:0]           imm20_u_o,
  output logic [19:0]           imm20_j_o,
  output logic [2:0]            imm_sel_o,
  output logic                  illegal_o
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic                  valid_q;
  logic [2:0]            imm_sel_q;
  logic                  illegal_q;

  logic [2:0]            imm_sel_d;
  logic                  illegal_d;

  // Format decode happens on the incoming opcode so it lands in the register with the instruction.
  always_comb begin
    imm_sel_d = 3'b010;
    illegal_d = 1'b0;
    unique case (instr_i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: imm_sel_d = 3'b000;
      7'b0100011:                                      imm_sel_d = 3'b001;
      7'b1100011:                                      imm_sel_d = 3'b011;
      7'b0110111, 7'b0010111:                          imm_sel_d = 3'b100;
      7'b1101111:                                      imm_sel_d = 3'b101;
      7'b0110011:                                      imm_sel_d = 3'b010;
      default: begin
        imm_sel_d = 3'b010;
        illegal_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      valid_q   <= 1'b0;
      imm_sel_q <= 3'b000;
      illegal_q <= 1'b0;
    end else if (flush_i) begin
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
      imm_sel_q <= 3'b000;
      illegal_q <= 1'b0;
    end else if (!stall_i) begin
      instr_q   <= valid_i ? instr_i : NOP_INSTR;
      pc_q      <= pc_i;
      valid_q   <= valid_i;
      imm_sel_q <= imm_sel_d;
      illegal_q <= illegal_d & valid_i;
    end
  end

`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_i && valid_q && !flush_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pc4_o     = pc_q + DATA_WIDTH'(4);
  assign valid_o   = valid_q;
  assign imm_sel_o = imm_sel_q;
  assign illegal_o = illegal_q;

  // B and J slices drop bit 0; the sign extender appends the zero.
  assign imm12_i_o = instr_q[31:20];
  assign imm12_s_o = {instr_q[31:25], instr_q[11:7]};
  assign imm12_b_o = {instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8]};
  assign imm20_u_o = instr_q[31:12];
  assign imm20_j_o = {instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21]};

endmodule

// File: tb/tb_if_id_imm_stage.sv
// Self-checking bench for if_id_imm_stage: directed test-plan steps followed by
// randomized traffic against a behavioural model of the stage.
module tb_if_id_imm_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_i, pc_i;
  logic        valid_i, stall_i, flush_i;
  logic [31:0] instr_o, pc_o, pc4_o;
  logic        valid_o;
  logic [11:0] imm12_i_o, imm12_s_o, imm12_b_o;
  logic [19:0] imm20_u_o, imm20_j_o;
  logic [2:0]  imm_sel_o;
  logic        illegal_o;
`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state
  logic [31:0] m_instr, m_pc;
  logic        m_valid, m_ill;
  logic [2:0]  m_sel;
  logic        m_sel_known;
  logic [31:0] m_cnt;
  logic [31:0] cnt_base;

  if_id_imm_stage #(.DATA_WIDTH(32), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .instr_i(instr_i), .pc_i(pc_i), .valid_i(valid_i),
    .stall_i(stall_i), .flush_i(flush_i), .instr_o(instr_o), .pc_o(pc_o),
    .pc4_o(pc4_o), .valid_o(valid_o), .imm12_i_o(imm12_i_o), .imm12_s_o(imm12_s_o),
    .imm12_b_o(imm12_b_o), .imm20_u_o(imm20_u_o), .imm20_j_o(imm20_j_o),
    .imm_sel_o(imm_sel_o), .illegal_o(illegal_o)
`ifdef IF_ID_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Format table: returns {illegal, sel}
  function automatic logic [3:0] fmt_of(input logic [6:0] op);
    case (op)
      7'h13, 7'h03, 7'h67, 7'h73: return 4'b0_000;
      7'h23:                      return 4'b0_001;
      7'h63:                      return 4'b0_011;
      7'h37, 7'h17:               return 4'b0_100;
      7'h6F:                      return 4'b0_101;
      7'h33:                      return 4'b0_010;
      default:                    return 4'b1_010;
    endcase
  endfunction

  // Immediates derived from the architectural sign-extended values, then truncated.
  function automatic logic [11:0] exp_b(input logic [31:0] w);
    logic [31:0] full;
    full = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    return full[12:1];
  endfunction

  function automatic logic [19:0] exp_j(input logic [31:0] w);
    logic [31:0] full;
    full = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    return full[20:1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] s_full;
    chk("instr", instr_o, m_instr);
    chk("pc", pc_o, m_pc);
    chk("pc4", pc4_o, m_pc + 32'd4);
    chk("valid", {31'd0, valid_o}, {31'd0, m_valid});
    chk("illegal", {31'd0, illegal_o}, {31'd0, m_ill});
    if (m_sel_known) chk("imm_sel", {29'd0, imm_sel_o}, {29'd0, m_sel});
    chk("imm_i", {20'd0, imm12_i_o}, {20'd0, m_instr[31:20]});
    s_full = {{20{m_instr[31]}}, m_instr[31:25], m_instr[11:7]};
    chk("imm_s", {20'd0, imm12_s_o}, {20'd0, s_full[11:0]});
    chk("imm_b", {20'd0, imm12_b_o}, {20'd0, exp_b(m_instr)});
    chk("imm_u", {12'd0, imm20_u_o}, {12'd0, m_instr[31:12]});
    chk("imm_j", {12'd0, imm20_j_o}, {12'd0, exp_j(m_instr)});
`ifdef IF_ID_STALL_CNT_EN
    chk("stall_cnt", stall_cnt_o, m_cnt);
`endif
  endtask

  // Apply inputs for one cycle, advance the model at the edge, then compare.
  task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                      input logic v, input logic st, input logic fl);
    logic [3:0] f;
    rst = r; instr_i = ins; pc_i = pc; valid_i = v; stall_i = st; flush_i = fl;
    @(posedge clk);
    if (r) begin
      m_instr = NOP; m_pc = '0; m_valid = 1'b0; m_sel = 3'b000; m_ill = 1'b0;
      m_sel_known = 1'b1; m_cnt = '0;
    end else begin
      if (st && m_valid && !fl && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (fl) begin
        m_instr = NOP; m_valid = 1'b0; m_sel = 3'b000; m_ill = 1'b0; m_sel_known = 1'b1;
      end else if (!st) begin
        f = fmt_of(ins[6:0]);
        m_instr = v ? ins : NOP;
        m_pc = pc;
        m_valid = v;
        m_sel = f[2:0];
        m_ill = f[3] & v;
        m_sel_known = v;
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] ins;
    logic [6:0]  ops [10];
    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    m_cnt = '0;

    // Reset then idle
    step(1, 32'hDEADBEEF, 32'h55, 1, 0, 0);
    step(1, 32'hDEADBEEF, 32'h55, 1, 0, 0);
    chk("rst_instr", instr_o, 32'h0000_0013);
    chk("rst_pc4", pc4_o, 32'd4);
    chk("rst_sel", {29'd0, imm_sel_o}, 32'd0);

    // S-type
    step(0, 32'hFE112E23, 32'h100, 1, 0, 0);
    chk("s_imm", {20'd0, imm12_s_o}, 32'hFFC);
    chk("s_sel", {29'd0, imm_sel_o}, 32'd1);
    chk("s_pc4", pc4_o, 32'h104);
    chk("s_valid", {31'd0, valid_o}, 32'd1);

    // J-type
    step(0, 32'h0080006F, 32'h104, 1, 0, 0);
    chk("j_imm", {12'd0, imm20_j_o}, 32'h00004);
    chk("j_sel", {29'd0, imm_sel_o}, 32'd5);

    // B-type
    step(0, 32'hFE000EE3, 32'h108, 1, 0, 0);
    chk("b_imm", {20'd0, imm12_b_o}, 32'hFFE);
    chk("b_sel", {29'd0, imm_sel_o}, 32'd3);

    // Stall holds, then flush wins over stall
    step(0, 32'h00500093, 32'h10C, 1, 0, 0);
    cnt_base = m_cnt;
    for (int i = 0; i < 3; i++) begin
      step(0, $urandom, $urandom, 1, 1, 0);
      chk("stall_hold", instr_o, 32'h00500093);
    end
    step(0, 32'h12345678, 32'h200, 1, 1, 1);
    chk("flush_instr", instr_o, 32'h0000_0013);
    chk("flush_valid", {31'd0, valid_o}, 32'd0);
    chk("flush_pc", pc_o, 32'h10C);

    // Illegal opcode, then same with valid low
    step(0, 32'h0000007F, 32'h300, 1, 0, 0);
    chk("ill_flag", {31'd0, illegal_o}, 32'd1);
    chk("ill_sel", {29'd0, imm_sel_o}, 32'd2);
    step(0, 32'h0000007F, 32'h304, 0, 0, 0);
    chk("inv_ill", {31'd0, illegal_o}, 32'd0);
    chk("inv_instr", instr_o, 32'h0000_0013);

    // PC wrap
    step(0, 32'h00000013, 32'hFFFF_FFFC, 1, 0, 0);
    chk("pc_wrap", pc4_o, 32'h0000_0000);

`ifdef IF_ID_STALL_CNT_EN
    cnt_base = m_cnt;
    for (int i = 0; i < 5; i++) step(0, $urandom, $urandom, 1, 1, 0);
    chk("stall_cnt5", stall_cnt_o - cnt_base, 32'd5);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[6:0] = ops[$urandom_range(0, 9)];
      step($urandom_range(0, 49) == 0, ins, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
